// File: rtl/x4xx_version_scanner.sv
// CtrlPort master that reads every component's version registers and flags HDL/SW incompatibilities.
// Optional macro X4XX_VERSION_SCAN_TIMESTAMP_EN adds a timestamp read (offset 0x8) and newest_timestamp.
module x4xx_version_scanner #(
  parameter logic [19:0] REG_BASE       = 20'h0,
  parameter int          NUM_COMPONENTS = 6,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                        ctrlport_clk,
  input  logic                        ctrlport_rst_n,
  input  logic                        start,
  input  logic [NUM_COMPONENTS*64-1:0] sw_versions,
  output logic                        m_ctrlport_req_rd,
  output logic                        m_ctrlport_req_wr,
  output logic [19:0]                 m_ctrlport_req_addr,
  output logic [31:0]                 m_ctrlport_req_data,
  input  logic                        m_ctrlport_resp_ack,
  input  logic [1:0]                  m_ctrlport_resp_status,
  input  logic [31:0]                 m_ctrlport_resp_data,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_COMPONENTS-1:0]   too_old_mask,
  output logic [NUM_COMPONENTS-1:0]   too_new_mask,
  output logic [NUM_COMPONENTS-1:0]   access_err_mask,
  output logic                        compatible
`ifdef X4XX_VERSION_SCAN_TIMESTAMP_EN
  ,
  output logic [31:0]                 newest_timestamp
`endif
);

  localparam int IDX_W = (NUM_COMPONENTS > 1) ? $clog2(NUM_COMPONENTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_COMPONENTS - 1);
  localparam logic [15:0]      TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, REQ_CUR, WAIT_CUR, REQ_OLD, WAIT_OLD, REQ_TS, WAIT_TS, EVAL, DONE
  } state_t;

  state_t                    state;
  logic [IDX_W-1:0]          index;
  logic [15:0]               timer;
  logic [31:0]               hdl_cur;
  logic [31:0]               hdl_old;
  logic                      cur_ok;
  logic                      old_ok;
  logic [19:0]               comp_addr;
  logic [NUM_COMPONENTS-1:0] idx_bit;
  logic [NUM_COMPONENTS-1:0] too_old_next;
  logic [NUM_COMPONENTS-1:0] too_new_next;
  logic [31:0]               sw_cur;
  logic [31:0]               sw_old;
  logic                      cmp_ok;
  logic                      wait_fin;
  logic                      wait_err;

  assign m_ctrlport_req_wr   = 1'b0;
  assign m_ctrlport_req_data = 32'h0;

  assign comp_addr = REG_BASE + {{(16-IDX_W){1'b0}}, index, 4'b0000};
  assign idx_bit   = NUM_COMPONENTS'(1) << index;
  assign sw_cur    = sw_versions[{index, 6'b000000} +: 32];
  assign sw_old    = sw_versions[{index, 6'b100000} +: 32];

  // An ack on the final timer cycle wins over the timeout; a timeout is treated like an error ack.
  assign wait_fin = m_ctrlport_resp_ack | (timer == TIMER_LAST);
  assign wait_err = ~m_ctrlport_resp_ack | (m_ctrlport_resp_status != 2'b00);

  assign cmp_ok       = cur_ok & old_ok;
  assign too_old_next = too_old_mask | ((cmp_ok && (sw_old > hdl_cur)) ? idx_bit : '0);
  assign too_new_next = too_new_mask | ((cmp_ok && (sw_cur < hdl_old)) ? idx_bit : '0);

  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      state               <= IDLE;
      index               <= '0;
      timer               <= '0;
      hdl_cur             <= '0;
      hdl_old             <= '0;
      cur_ok              <= 1'b0;
      old_ok              <= 1'b0;
      m_ctrlport_req_rd   <= 1'b0;
      m_ctrlport_req_addr <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      too_old_mask        <= '0;
      too_new_mask        <= '0;
      access_err_mask     <= '0;
      compatible          <= 1'b0;
`ifdef X4XX_VERSION_SCAN_TIMESTAMP_EN
      newest_timestamp    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            too_old_mask        <= '0;
            too_new_mask        <= '0;
            access_err_mask     <= '0;
            compatible          <= 1'b0;
            index               <= '0;
            busy                <= 1'b1;
            m_ctrlport_req_rd   <= 1'b1;
            m_ctrlport_req_addr <= REG_BASE;
            state               <= REQ_CUR;
`ifdef X4XX_VERSION_SCAN_TIMESTAMP_EN
            newest_timestamp    <= '0;
`endif
          end
        end
        REQ_CUR: begin
          m_ctrlport_req_rd <= 1'b0;
          timer             <= '0;
          cur_ok            <= 1'b0;
          state             <= WAIT_CUR;
        end
        WAIT_CUR: begin
          if (wait_fin) begin
            if (wait_err) begin
              access_err_mask <= access_err_mask | idx_bit;
            end else begin
              hdl_cur <= m_ctrlport_resp_data;
              cur_ok  <= 1'b1;
            end
            m_ctrlport_req_rd   <= 1'b1;
            m_ctrlport_req_addr <= comp_addr + 20'h4;
            state               <= REQ_OLD;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        REQ_OLD: begin
          m_ctrlport_req_rd <= 1'b0;
          timer             <= '0;
          old_ok            <= 1'b0;
          state             <= WAIT_OLD;
        end
        WAIT_OLD: begin
          if (wait_fin) begin
            if (wait_err) begin
              access_err_mask <= access_err_mask | idx_bit;
            end else begin
              hdl_old <= m_ctrlport_resp_data;
              old_ok  <= 1'b1;
            end
`ifdef X4XX_VERSION_SCAN_TIMESTAMP_EN
            m_ctrlport_req_rd   <= 1'b1;
            m_ctrlport_req_addr <= comp_addr + 20'h8;
            state               <= REQ_TS;
`else
            state               <= EVAL;
`endif
          end else begin
            timer <= timer + 16'd1;
          end
        end
`ifdef X4XX_VERSION_SCAN_TIMESTAMP_EN
        REQ_TS: begin
          m_ctrlport_req_rd <= 1'b0;
          timer             <= '0;
          state             <= WAIT_TS;
        end
        WAIT_TS: begin
          if (wait_fin) begin
            if (wait_err) begin
              access_err_mask <= access_err_mask | idx_bit;
            end else if (m_ctrlport_resp_data > newest_timestamp) begin
              newest_timestamp <= m_ctrlport_resp_data;
            end
            state <= EVAL;
          end else begin
            timer <= timer + 16'd1;
          end
        end
`endif
        EVAL: begin
          too_old_mask <= too_old_next;
          too_new_mask <= too_new_next;
          if (index == LAST_IDX) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            compatible <= ~|(too_old_next | too_new_next | access_err_mask);
            state      <= DONE;
          end else begin
            index               <= index + IDX_W'(1);
            m_ctrlport_req_rd   <= 1'b1;
            m_ctrlport_req_addr <= comp_addr + 20'h10;
            state               <= REQ_CUR;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x4xx_version_scanner.sv
// Directed bench for x4xx_version_scanner: a bench-side CtrlPort responder plus a
// schedule/mask model derived from the read sequence, checked every cycle.
module tb_x4xx_version_scanner;

  localparam int NC = 2;
  localparam int TO = 4;
`ifdef X4XX_VERSION_SCAN_TIMESTAMP_EN
  localparam int NREADS   = 3;
  localparam int LAT_BASE = 15;
  localparam int LAT_TO   = 18;
`else
  localparam int NREADS   = 2;
  localparam int LAT_BASE = 11;
  localparam int LAT_TO   = 14;
`endif

  logic              ctrlport_clk = 1'b0;
  logic              ctrlport_rst_n = 1'b0;
  logic              start = 1'b0;
  logic [NC*64-1:0]  sw_versions = '0;
  logic              m_ctrlport_req_rd;
  logic              m_ctrlport_req_wr;
  logic [19:0]       m_ctrlport_req_addr;
  logic [31:0]       m_ctrlport_req_data;
  logic              m_ctrlport_resp_ack = 1'b0;
  logic [1:0]        m_ctrlport_resp_status = 2'b00;
  logic [31:0]       m_ctrlport_resp_data = 32'h0;
  logic              busy;
  logic              done;
  logic [NC-1:0]     too_old_mask;
  logic [NC-1:0]     too_new_mask;
  logic [NC-1:0]     access_err_mask;
  logic              compatible;
`ifdef X4XX_VERSION_SCAN_TIMESTAMP_EN
  logic [31:0]       newest_timestamp;
`endif

  x4xx_version_scanner #(
    .REG_BASE       (20'h0),
    .NUM_COMPONENTS (NC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .ctrlport_clk           (ctrlport_clk),
    .ctrlport_rst_n         (ctrlport_rst_n),
    .start                  (start),
    .sw_versions            (sw_versions),
    .m_ctrlport_req_rd      (m_ctrlport_req_rd),
    .m_ctrlport_req_wr      (m_ctrlport_req_wr),
    .m_ctrlport_req_addr    (m_ctrlport_req_addr),
    .m_ctrlport_req_data    (m_ctrlport_req_data),
    .m_ctrlport_resp_ack    (m_ctrlport_resp_ack),
    .m_ctrlport_resp_status (m_ctrlport_resp_status),
    .m_ctrlport_resp_data   (m_ctrlport_resp_data),
    .busy                   (busy),
    .done                   (done),
    .too_old_mask           (too_old_mask),
    .too_new_mask           (too_new_mask),
    .access_err_mask        (access_err_mask),
    .compatible             (compatible)
`ifdef X4XX_VERSION_SCAN_TIMESTAMP_EN
    ,
    .newest_timestamp       (newest_timestamp)
`endif
  );

  always #5 ctrlport_clk = ~ctrlport_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Responder contents and fault injection knobs
  logic [31:0] resp_cur [NC];
  logic [31:0] resp_old [NC];
  logic [31:0] sw_cur [NC];
  logic [31:0] sw_old [NC];
  logic [19:0] err_addr;
  logic [19:0] noack_addr;
  int          inject_cyc = -1;

  // Model of the current scan
  logic        scan_active = 1'b0;
  int          s_cyc;
  int          exp_done;
  int          n_req;
  int          req_cyc [8];
  logic [19:0] req_addr [8];
  logic [NC-1:0] exp_too_old, exp_too_new, exp_err;
  logic        exp_compat;
  logic [NC-1:0] held_too_old = '0, held_too_new = '0, held_err = '0;
  logic        held_compat = 1'b0;
  logic [19:0] obs_addr [$];
  int          obs_done;
  logic        exp_req;
  logic [19:0] exp_a;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  initial forever begin
    @(posedge ctrlport_clk);
    cyc++;
  end

  // Responder: acks the cycle after a request, except for the no-ack address
  initial begin
    logic        p_req;
    logic [19:0] p_addr;
    int          ridx;
    forever begin
      @(negedge ctrlport_clk);
      p_req  = m_ctrlport_req_rd;
      p_addr = m_ctrlport_req_addr;
      @(posedge ctrlport_clk);
      #1;
      m_ctrlport_resp_ack    = 1'b0;
      m_ctrlport_resp_status = 2'b00;
      m_ctrlport_resp_data   = 32'h0;
      if (p_req && p_addr != noack_addr) begin
        ridx = int'(p_addr[19:4]);
        m_ctrlport_resp_ack    = 1'b1;
        m_ctrlport_resp_status = (p_addr == err_addr) ? 2'b01 : 2'b00;
        if (ridx < NC) begin
          case (p_addr[3:0])
            4'h0:    m_ctrlport_resp_data = resp_cur[ridx];
            4'h4:    m_ctrlport_resp_data = resp_old[ridx];
            default: m_ctrlport_resp_data = 32'h1000 + 32'(ridx);
          endcase
        end
      end else if (cyc == inject_cyc) begin
        m_ctrlport_resp_ack    = 1'b1;
        m_ctrlport_resp_status = 2'b01;
        m_ctrlport_resp_data   = 32'hFFFF_FFFF;
      end
    end
  end

  // Per-cycle compare against the model
  initial forever begin
    @(negedge ctrlport_clk);
    if (ctrlport_rst_n) begin
      checkOutput("req_wr", 32'(m_ctrlport_req_wr), 32'h0);
      checkOutput("req_data", m_ctrlport_req_data, 32'h0);
      if (scan_active) begin
        exp_req = 1'b0;
        exp_a   = '0;
        for (int k = 0; k < n_req; k++)
          if (req_cyc[k] == cyc) begin
            exp_req = 1'b1;
            exp_a   = req_addr[k];
          end
        checkOutput("req_rd", 32'(m_ctrlport_req_rd), 32'(exp_req));
        if (exp_req) checkOutput("req_addr", 32'(m_ctrlport_req_addr), 32'(exp_a));
        if (m_ctrlport_req_rd) obs_addr.push_back(m_ctrlport_req_addr);
        checkOutput("busy", 32'(busy), 32'(cyc > s_cyc && cyc < exp_done));
        checkOutput("done", 32'(done), 32'(cyc == exp_done));
        if (done) obs_done = cyc;
        if (cyc == exp_done) begin
          checkOutput("too_old_mask", 32'(too_old_mask), 32'(exp_too_old));
          checkOutput("too_new_mask", 32'(too_new_mask), 32'(exp_too_new));
          checkOutput("access_err_mask", 32'(access_err_mask), 32'(exp_err));
          checkOutput("compatible", 32'(compatible), 32'(exp_compat));
          held_too_old = exp_too_old;
          held_too_new = exp_too_new;
          held_err     = exp_err;
          held_compat  = exp_compat;
          scan_active  = 1'b0;
        end
      end else begin
        checkOutput("idle_req_rd", 32'(m_ctrlport_req_rd), 32'h0);
        checkOutput("idle_busy", 32'(busy), 32'h0);
        checkOutput("idle_done", 32'(done), 32'h0);
        checkOutput("idle_too_old", 32'(too_old_mask), 32'(held_too_old));
        checkOutput("idle_too_new", 32'(too_new_mask), 32'(held_too_new));
        checkOutput("idle_err", 32'(access_err_mask), 32'(held_err));
        checkOutput("idle_compat", 32'(compatible), 32'(held_compat));
      end
    end
  end

  task automatic setBase();
    for (int i = 0; i < NC; i++) begin
      resp_cur[i] = 32'h0080_1000;
      resp_old[i] = 32'h0080_0000;
      sw_cur[i]   = 32'h0080_1000;
      sw_old[i]   = 32'h0080_0000;
    end
    err_addr   = 20'hFFFFF;
    noack_addr = 20'hFFFFF;
  endtask

  // Pulses start, builds the expected schedule, then optionally re-pulses start,
  // injects a stray ack, or aborts with reset at the given cycle offsets.
  task automatic applyStimulus(input int extra_start_off, input int abort_off, input int inject_off);
    int t;
    logic cur_bad, old_bad, rbad;
    logic [19:0] a;
    for (int i = 0; i < NC; i++) begin
      sw_versions[64*i +: 32]    = sw_cur[i];
      sw_versions[64*i+32 +: 32] = sw_old[i];
    end
    @(posedge ctrlport_clk);
    #1;
    start = 1'b1;
    s_cyc = cyc;
    t = s_cyc + 1;
    n_req = 0;
    exp_too_old = '0;
    exp_too_new = '0;
    exp_err = '0;
    for (int i = 0; i < NC; i++) begin
      cur_bad = 1'b0;
      old_bad = 1'b0;
      for (int r = 0; r < NREADS; r++) begin
        a = 20'(i*16 + r*4);
        req_cyc[n_req]  = t;
        req_addr[n_req] = a;
        n_req++;
        if (a == noack_addr) begin
          t += 1 + TO;
          rbad = 1'b1;
        end else begin
          t += 2;
          rbad = (a == err_addr);
        end
        if (rbad) exp_err[i] = 1'b1;
        if (r == 0) cur_bad = rbad;
        if (r == 1) old_bad = rbad;
      end
      if (!cur_bad && !old_bad) begin
        if (sw_old[i] > resp_cur[i]) exp_too_old[i] = 1'b1;
        if (sw_cur[i] < resp_old[i]) exp_too_new[i] = 1'b1;
      end
      t += 1;
    end
    exp_done   = t;
    exp_compat = ((exp_too_old | exp_too_new | exp_err) == '0);
    inject_cyc = (inject_off != 0) ? exp_done - inject_off : -1;
    obs_addr.delete();
    obs_done = -1;
    scan_active = 1'b1;
    for (int k = 1; k <= 2000 && scan_active; k++) begin
      @(posedge ctrlport_clk);
      #1;
      start = (k == extra_start_off);
      if (k == abort_off) begin
        #2;
        ctrlport_rst_n = 1'b0;
        scan_active  = 1'b0;
        held_too_old = '0;
        held_too_new = '0;
        held_err     = '0;
        held_compat  = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_req_rd", 32'(m_ctrlport_req_rd), 32'h0);
        checkOutput("abort_req_addr", 32'(m_ctrlport_req_addr), 32'h0);
        checkOutput("abort_err", 32'(access_err_mask), 32'h0);
        checkOutput("abort_compat", 32'(compatible), 32'h0);
        repeat (2) @(posedge ctrlport_clk);
        #3;
        ctrlport_rst_n = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (scan_active) begin
      total++;
      bad++;
      $display("[TB] FAIL scan_wait: scan still active, required done by cycle %0d", exp_done);
      scan_active = 1'b0;
    end
    repeat (2) @(posedge ctrlport_clk);
    #1;
  endtask

  initial begin
    setBase();
    repeat (3) @(posedge ctrlport_clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_req_rd", 32'(m_ctrlport_req_rd), 32'h0);
    checkOutput("rst_masks", 32'({too_old_mask, too_new_mask, access_err_mask}), 32'h0);
    checkOutput("rst_compat", 32'(compatible), 32'h0);
    ctrlport_rst_n = 1'b1;
    repeat (2) @(posedge ctrlport_clk);

    $display("[TB] all compatible");
    applyStimulus(0, 0, 0);
    checkOutput("base_latency", 32'(obs_done - s_cyc), 32'(LAT_BASE));
`ifndef X4XX_VERSION_SCAN_TIMESTAMP_EN
    checkOutput("base_n_reads", 32'(obs_addr.size()), 32'd4);
    checkOutput("base_addr0", 32'(obs_addr[0]), 32'h0);
    checkOutput("base_addr1", 32'(obs_addr[1]), 32'h4);
    checkOutput("base_addr2", 32'(obs_addr[2]), 32'h10);
    checkOutput("base_addr3", 32'(obs_addr[3]), 32'h14);
`endif
    checkOutput("base_compat_lit", 32'(compatible), 32'h1);

    $display("[TB] component 1 too new");
    resp_old[1] = 32'h0100_0000;
    applyStimulus(0, 0, 0);
    checkOutput("too_new_lit", 32'(too_new_mask), 32'h2);
    checkOutput("too_new_old_lit", 32'(too_old_mask), 32'h0);
    checkOutput("too_new_compat_lit", 32'(compatible), 32'h0);

    $display("[TB] component 0 too old, then equal");
    setBase();
    resp_cur[0] = 32'h0070_0000;
    applyStimulus(0, 0, 0);
    checkOutput("too_old_lit", 32'(too_old_mask), 32'h1);
    sw_old[0] = 32'h0070_0000;
    applyStimulus(0, 0, 0);
    checkOutput("equal_lit", 32'(too_old_mask), 32'h0);
    checkOutput("equal_compat_lit", 32'(compatible), 32'h1);

    $display("[TB] timeout on 0x14 with stray ack");
    setBase();
    noack_addr = 20'h14;
    applyStimulus(0, 0, 1);
    checkOutput("timeout_err_lit", 32'(access_err_mask), 32'h2);
    checkOutput("timeout_latency", 32'(obs_done - s_cyc), 32'(LAT_TO));

    $display("[TB] error status on 0x0");
    setBase();
    err_addr = 20'h0;
    applyStimulus(0, 0, 0);
    checkOutput("errst_err_lit", 32'(access_err_mask), 32'h1);
    checkOutput("errst_addr1", 32'(obs_addr[1]), 32'h4);
    checkOutput("errst_latency", 32'(obs_done - s_cyc), 32'(LAT_BASE));

    $display("[TB] start while busy");
    setBase();
    applyStimulus(3, 0, 0);
    checkOutput("restart_compat_lit", 32'(compatible), 32'h1);

    $display("[TB] reset mid-wait, then fresh scan");
    applyStimulus(0, 2, 0);
    repeat (3) @(posedge ctrlport_clk);
    applyStimulus(0, 0, 0);
    checkOutput("fresh_addr0", 32'(obs_addr[0]), 32'h0);
    checkOutput("fresh_compat_lit", 32'(compatible), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
